// File: rtl/ring_buffer_pkg.sv
// Shared types and default sizes for the ring-buffer load path.
package ring_buffer_pkg;

   localparam int RB_WIDTH = 16;
   localparam int RB_DEPTH = 8;

   typedef logic [RB_WIDTH-1:0] rb_word_t;

   typedef enum logic [2:0] {
      FILL,
      LISTEN,
      LEAD_WAIT,
      SEND,
      GAP_WAIT,
      DONE
   } rbtx_state_t;

endpackage

// File: rtl/ring_buffer_tx_if.sv
// Upstream valid/ready stream plus the listen/strobe/din load bus of the ring-buffer transmitter.
interface ring_buffer_tx_if
   import ring_buffer_pkg::*;
#(
   parameter int WIDTH = RB_WIDTH
);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             listen;
   logic             strobe;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             frame_done;

   // master is the traffic source / monitor side, slave is the transmitter
   modport master (
      output in_valid, in_data,
      input  in_ready, listen, strobe, din, busy, frame_done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, listen, strobe, din, busy, frame_done
   );

endinterface

// File: rtl/rbtx_stage_mem.sv
// DEPTH x WIDTH staging register file with one write port and a registered read port feeding din.
module rbtx_stage_mem
   import ring_buffer_pkg::*;
#(
   parameter int WIDTH = RB_WIDTH,
   parameter int DEPTH = RB_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset; every slot is written during FILL before it is read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/ring_buffer_tx.sv
// Ring-buffer transmitter: stages DEPTH words, then sends listen followed by DEPTH strobes.
// Optional counters frames_sent/stall_cycles are built when RING_BUFFER_TX_STATS_EN is defined.
module ring_buffer_tx
   import ring_buffer_pkg::*;
#(
   parameter int WIDTH = RB_WIDTH,
   parameter int DEPTH = RB_DEPTH,
   parameter int LEAD  = 1,
   parameter int GAP   = 1
) (
   input  logic            clk,
   input  logic            reset,
   ring_buffer_tx_if.slave bus
`ifdef RING_BUFFER_TX_STATS_EN
   ,
   output logic [15:0]     frames_sent,
   output logic [15:0]     stall_cycles
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [3:0]    LEAD_END = 4'(LEAD - 1);
   localparam logic [3:0]    GAP_END  = 4'(GAP - 1);

   rbtx_state_t   state, next;
   logic [AW-1:0] wcnt, rcnt, raddr;
   logic [3:0]    dcnt;
   logic          accept, rd_en;
   logic          in_ready_q, listen_q, strobe_q, busy_q, done_q;
   logic [WIDTH-1:0] din_q;

   assign accept = bus.in_valid && in_ready_q;

   // The word for a strobe is fetched on the edge that enters SEND; in back-to-back
   // SEND the word currently on din is rcnt, so the next one is rcnt+1.
   assign rd_en = (next == SEND);
   assign raddr = (state == SEND) ? rcnt + 1'b1 : rcnt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next = state;
      unique case (state)
         FILL:      if (accept && wcnt == LAST) next = LISTEN;
         LISTEN:    next = (LEAD > 0) ? LEAD_WAIT : SEND;
         LEAD_WAIT: if (dcnt == LEAD_END) next = SEND;
         SEND: begin
            if (rcnt == LAST)  next = DONE;
            else if (GAP > 0)  next = GAP_WAIT;
            else               next = SEND;
         end
         GAP_WAIT:  if (dcnt == GAP_END) next = SEND;
         DONE:      next = FILL;
         default:   next = FILL;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FILL;
         wcnt       <= '0;
         rcnt       <= '0;
         dcnt       <= '0;
         in_ready_q <= 1'b0;
         listen_q   <= 1'b0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= next;
         in_ready_q <= (next == FILL);
         listen_q   <= (next == LISTEN);
         strobe_q   <= (next == SEND);
         busy_q     <= (next != FILL);
         done_q     <= (next == DONE);
         dcnt       <= ((state == LEAD_WAIT || state == GAP_WAIT) && next == state) ?
                       dcnt + 1'b1 : '0;
         if (accept) wcnt <= wcnt + 1'b1;
         if (state == SEND) rcnt <= rcnt + 1'b1;
         if (state == DONE) begin
            wcnt <= '0;
            rcnt <= '0;
         end
      end
   end

   rbtx_stage_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stage (
      .clk   (clk),
      .reset (reset),
      .we    (accept),
      .waddr (wcnt),
      .wdata (bus.in_data),
      .re    (rd_en),
      .raddr (raddr),
      .rdata (din_q)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.listen     = listen_q;
   assign bus.strobe     = strobe_q;
   assign bus.din        = din_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

`ifdef RING_BUFFER_TX_STATS_EN
   // Stall cycles only count once the current frame has started filling (wcnt != 0).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frames_sent  <= '0;
         stall_cycles <= '0;
      end else begin
         if (state == DONE) frames_sent <= frames_sent + 1'b1;
         if (state == FILL && wcnt != '0 && !bus.in_valid && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: doc/ring_buffer_tx.md
Name: ring_buffer_tx

Overview:
- Transmit end of the ring-buffer load protocol; drives listen/strobe/din into the ring buffer.
- Collects DEPTH words from an upstream valid/ready stream into a staging store.
- Once full, announces the frame with a listen pulse, then strobes the words out in order (index 0 first).
- Sits between the test/traffic source and the ring buffer; the existing ring-buffer monitor observes its outputs unchanged.

Parameters:
- WIDTH, 16, data word width (din, in_data).
- DEPTH, 8, words per frame; power of 2, at least 2.
- LEAD, 1, idle cycles between the listen pulse and the first strobe (0..15).
- GAP, 1, idle cycles between consecutive strobes (0..15); GAP=0 gives back-to-back strobes.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low: asserted when 0.
- in_valid  in  1  upstream word valid.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  high in FILL state only.
- listen  out  1  one-cycle frame-start pulse to the ring buffer.
- strobe  out  1  one-cycle pulse; din valid while high.
- din  out  WIDTH  word being delivered; held at last value between strobes.
- busy  out  1  high in every state except FILL.
- frame_done  out  1  one-cycle pulse in the cycle after the last strobe.

Behaviour:
- Reset values: in_ready=0, listen=0, strobe=0, din=0, busy=0, frame_done=0. Word counter cleared; staging contents don't-care. FSM enters FILL on the first clock after deassertion, so in_ready rises one cycle after release.
- All outputs are registered.
- FSM states: FILL, LISTEN, LEAD_WAIT, SEND, GAP_WAIT, DONE.
- FILL:
  - A word is accepted when in_valid && in_ready; it is written to staging[wcnt] and wcnt increments.
  - On accepting word DEPTH-1, go to LISTEN; in_ready drops the next cycle.
- LISTEN: listen=1 for exactly one cycle. Next state is LEAD_WAIT if LEAD>0, else SEND.
- LEAD_WAIT: counts LEAD cycles, then SEND.
- SEND:
  - strobe=1 for exactly one cycle, with din=staging[rcnt]; rcnt increments.
  - If more words remain: GAP_WAIT if GAP>0, else stay in SEND.
  - After word DEPTH-1: DONE.
- GAP_WAIT: strobe=0, din held; counts GAP cycles, then SEND.
- DONE: frame_done=1 for one cycle; wcnt and rcnt cleared; go to FILL.
- Timing: first strobe occurs LEAD+1 cycles after listen. Frame length is 1 + LEAD + DEPTH + (DEPTH-1)*GAP cycles from listen to the last strobe, plus 1 cycle for DONE.
- Counters are log2(DEPTH) bits and wrap naturally; no overflow handling is required because states gate them.
- in_valid while in_ready=0: the word is not consumed, and upstream must hold it.
- listen and strobe are never high in the same cycle. Neither is asserted while reset is active.
- Reset mid-frame (any state): outputs return to reset values immediately (asynchronous). The partial frame is discarded, with no further strobes and no frame_done.
- in_data is X while in_valid=0: ignored, never stored.

Optional Feature:
- Macro: RING_BUFFER_TX_STATS_EN.
- Defined:
  - Adds output frames_sent [15:0], reset to 0, incremented in DONE; wraps 16'hFFFF to 0.
  - Adds output stall_cycles [15:0]: counts FILL cycles with in_valid=0 after at least one word of the current frame was accepted; saturates at 16'hFFFF; cleared only by reset.
- Undefined: neither port exists and the counters are not built; all other behaviour is identical.

Decomposition:
- Shared package ring_buffer_pkg holds:
  - typedef enum logic [2:0] rbtx_state_t {FILL, LISTEN, LEAD_WAIT, SEND, GAP_WAIT, DONE};
  - localparam RB_WIDTH=16 and RB_DEPTH=8;
  - typedef logic [RB_WIDTH-1:0] rb_word_t.
- Sub-module rbtx_stage_mem: DEPTH x WIDTH register file with a write port (we, waddr, wdata) and a registered read (raddr -> rdata). It is used so din is registered directly from storage. The FSM, counters and output registers stay in the top module.

Test Plan:
- Basic frame: defaults; push 16'h1000..16'h1007 with in_valid held high -> in_ready high 8 cycles; listen pulse; 2 cycles later first strobe with din=16'h1000; strobes every 2 cycles ending with 16'h1007; frame_done 1 cycle after the last strobe; in_ready high again the following cycle.
- Back-to-back: GAP=0, LEAD=0; push 8 words -> strobe high 8 consecutive cycles immediately after listen, din sequencing 0..7 in order.
- Upstream stalls: toggle in_valid randomly during fill with words 16'hA0A0+i -> strobed data matches order exactly; no strobe before the 8th accept; in_ready=0 throughout the transmit phase, and words presented then are not consumed.
- Reset mid-frame: assert reset (0) after the 3rd strobe -> listen, strobe, din and busy go to 0 asynchronously within the same cycle; no frame_done; after release a fresh 8-word frame transmits correctly from index 0.
- Two consecutive frames: 16 words pushed continuously -> two listen pulses, 16 strobes, two frame_done pulses. With RING_BUFFER_TX_STATS_EN defined, frames_sent reads 2 afterwards and stall_cycles reads 0.
